// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential Booth multiplier:
//   - state_t           : controller state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH     : default operand width
//   - MOST_NEG_DEFAULT  : most-negative operand at the default width, the one
//                         multiplicand value the Booth datapath cannot handle
//   - cnt_width()       : width of the substep counter for a given operand width
// ---------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG_DEFAULT = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    // One extra bit over $clog2 so the counter can represent WIDTH itself
    // and therefore never wraps inside an operation.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : booth_pkg

// File: rtl/booth_substep.sv
// ---------------------------------------------------------------------------
// booth_substep
// One radix-2 Booth iteration, purely combinational.
//   acc, q, q0, m           : current accumulator, multiplier, guard bit, multiplicand
//   acc_next, q_next, q0_next: state after the add/subtract and the arithmetic
//                              right shift of {acc, q, q0}
// {q[0], q0} = 01 adds m, 10 subtracts m, 00/11 leave acc unchanged.
// ---------------------------------------------------------------------------
module booth_substep #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q0,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q0_next
);

    logic [WIDTH-1:0] sum;

    // NOTE: every branch of a combinational block must assign its outputs;
    // the default assignment up front is what keeps a latch from being inferred.
    always_comb begin
        sum = acc;
        unique case ({q[0], q0})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // Arithmetic shift of {sum, q, q0}: the sign of sum is replicated into
    // the top bit, the low bit of sum moves into q, and q[0] becomes the guard.
    assign acc_next = {sum[WIDTH-1], sum[WIDTH-1:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q0_next  = q[0];

endmodule : booth_substep

// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
// Sequential radix-2 Booth multiplier: one booth_substep per clock, WIDTH
// steps per product, with a start/ready/done handshake.
//   clk          : clock, rising edge
//   rst          : asynchronous, active-high reset
//   start        : operation request, accepted only while ready=1
//   multiplicand : signed M, sampled on an accepted start
//   multiplier   : signed Q, sampled on an accepted start
//   ready        : can accept start (IDLE or DONE)
//   busy         : iteration in progress (RUN)
//   done         : one-cycle pulse, product/range_err just updated
//   product      : signed 2*WIDTH-bit result, held until the next completion
//   range_err    : multiplicand was the most-negative value; product invalid
// ---------------------------------------------------------------------------
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               range_err
);

    localparam int               CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             q0;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] q_step;
    logic             q0_step;

    logic             accept;
    logic             last_step;

    // Start is honoured only from a state that advertises ready; ready is a
    // decode of the state register, so there is no comb path start -> outputs.
    assign accept    = start && (state != ST_RUN);
    assign last_step = (state == ST_RUN) && (count == LAST_COUNT);

    booth_substep #(
        .WIDTH (WIDTH)
    ) u_substep (
        .acc      (acc),
        .q        (q),
        .q0       (q0),
        .m        (m),
        .acc_next (acc_step),
        .q_next   (q_step),
        .q0_next  (q0_step)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  busy  = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers and substep counter
    // -----------------------------------------------------------------------
    // NOTE: these are plain flops, not a memory, so all of them take the
    // reset; a reset mid-operation must leave no trace of the discarded result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            q         <= '0;
            q0        <= 1'b0;
            m         <= '0;
            count     <= '0;
            product   <= '0;
            range_err <= 1'b0;
        end else if (accept) begin
            acc   <= '0;
            q     <= multiplier;
            q0    <= 1'b0;
            m     <= multiplicand;
            count <= '0;
        end else if (state == ST_RUN) begin
            acc   <= acc_step;
            q     <= q_step;
            q0    <= q0_step;
            count <= count + 1'b1;
            if (last_step) begin
                product   <= {acc_step, q_step};
                // -M is not representable in WIDTH bits for this operand,
                // so the subtraction overflows and the product is unusable.
                range_err <= (m == MOST_NEG);
            end
        end
    end

endmodule : booth_seq_multiplier

// File: tb/tb_booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_multiplier
// Self-checking bench for booth_seq_multiplier at WIDTH=64. Expected products
// come from a plain signed 128-bit multiply of the sign-extended operands.
// ---------------------------------------------------------------------------
module tb_booth_seq_multiplier;
    import booth_pkg::*;

    localparam int W      = 64;
    localparam int BUDGET = 200;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           range_err;

    int n_checks = 0;
    int n_pass   = 0;

    booth_seq_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .range_err    (range_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [2*W-1:0] actual,
                         input logic [2*W-1:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        else
            n_pass++;
    endtask

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        return sa * sb;
    endfunction

    // Called #1 after the edge that accepted start. Returns edges until done
    // is seen and how many sampled cycles showed busy along the way.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < BUDGET) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Full operation from a ready state; caller is positioned #1 after an edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int   edges;
        int   busy_cycles;
        logic exp_err;
        exp_err      = (a == MOST_NEG_DEFAULT);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        wait_done(edges, busy_cycles);
        check({tag, "_latency"}, 128'(edges), 128'(W));
        check({tag, "_busy"}, 128'(busy_cycles), 128'(W));
        check({tag, "_range_err"}, 128'(range_err), 128'(exp_err));
        if (!exp_err)
            check({tag, "_product"}, product, model_product(a, b));
    endtask

    initial begin
        int            edges;
        int            busy_cycles;
        int            done_seen;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        rst          = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #2 rst = 1'b1;
        #10;
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_product", product, 128'(0));
        check("rst_range_err", 128'(range_err), 128'(0));
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed products
        do_op(64'd3, 64'd5, "m3_q5");
        do_op(-64'sd7, 64'd3, "mneg7_q3");
        do_op(-64'sd1, -64'sd1, "mneg1_qneg1");
        do_op(64'd1, 64'hF0F0_F0F0_F0F0_F0F0, "m1_qpattern");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "maxpos_minneg");
        do_op(64'd0, 64'hDEAD_BEEF_0123_4567, "zero_m");

        // Randomized operands; the most-negative multiplicand is covered separately
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (ra == MOST_NEG_DEFAULT) ra = 64'd1;
            if (i % 4 == 1) ra = 64'($signed(32'($urandom_range(0, 255)) - 32'sd128));
            do_op(ra, rb, $sformatf("rand%0d", i));
        end

        // start while busy must be ignored
        multiplicand = 64'd100;
        multiplier   = 64'd200;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        multiplicand = 64'd7;
        multiplier   = 64'd7;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_still_busy", 128'(busy), 128'(1));
        wait_done(edges, busy_cycles);
        check("busy_start_latency", 128'(edges + 11), 128'(W));
        check("busy_start_product", product, model_product(64'd100, 64'd200));

        // Back-to-back: start held through DONE with new operands
        multiplicand = 64'd9;
        multiplier   = 64'd11;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 64'd2;
        multiplier   = -64'sd4;
        wait_done(edges, busy_cycles);
        check("b2b_first_latency", 128'(edges), 128'(W));
        check("b2b_first_product", product, model_product(64'd9, 64'd11));
        check("b2b_ready_in_done", 128'(ready), 128'(1));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_no_idle", 128'(busy), 128'(1));
        check("b2b_first_held", product, model_product(64'd9, 64'd11));
        wait_done(edges, busy_cycles);
        check("b2b_second_latency", 128'(edges), 128'(W));
        check("b2b_second_product", product, model_product(64'd2, -64'sd4));

        // Asynchronous reset in the middle of an operation
        multiplicand = 64'd12345;
        multiplier   = 64'd678;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 128'(ready), 128'(1));
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_product", product, 128'(0));
        #3 rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("arst_no_done", 128'(done_seen), 128'(0));
        do_op(64'd6, 64'd7, "after_rst");

        // Most-negative multiplicand flags range_err, next valid op clears it
        do_op(MOST_NEG_DEFAULT, 64'd1, "mostneg");
        do_op(64'd5, 64'd5, "clear_err");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_booth_seq_multiplier
